// File: rtl/libhdl_pulse_queue.sv
// Multi-channel pulse queue: counts events per channel in saturating counters and replays
// them one at a time through a round-robin arbiter with a programmable minimum gap.
module libhdl_pulse_queue #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned GAP      = 0,
  parameter int unsigned OREG     = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [CHANNELS-1:0] i_pulse,
  input  logic [CHANNELS-1:0] i_clrOvf,
  output logic [CHANNELS-1:0] o_pulse,
  output logic                o_any,
  output logic [CHANNELS-1:0] o_pending,
  output logic [CHANNELS-1:0] o_full,
  output logic [CHANNELS-1:0] o_overflow
);

  localparam int unsigned PtrW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [CHANNELS-1:0] eligible, grant;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic                gap_ok;
  logic                found;
  int unsigned         idx;

  always_comb begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      eligible[k] = (cnt_q[k] != '0);
      o_full[k]   = (cnt_q[k] == CntMax);
    end
  end

  // Search starts at ptr and wraps; the first eligible channel wins.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    if (gap_ok) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        idx = (32'(ptr_q) + i) % CHANNELS;
        if (!found && eligible[idx]) begin
          grant[idx] = 1'b1;
          ptr_d      = PtrW'((idx + 1) % CHANNELS);
          found      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      cnt_d[k] = cnt_q[k];
      ovf_d[k] = ovf_q[k] & ~i_clrOvf[k];
      case ({i_pulse[k], grant[k]})
        2'b10: begin
          if (cnt_q[k] == CntMax) ovf_d[k] = 1'b1;
          else                    cnt_d[k] = cnt_q[k] + 1'b1;
        end
        2'b01:   cnt_d[k] = cnt_q[k] - 1'b1;
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < CHANNELS; k++) cnt_q[k] <= '0;
      ovf_q <= '0;
      ptr_q <= '0;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) cnt_q[k] <= cnt_d[k];
      ovf_q <= ovf_d;
      ptr_q <= ptr_d;
    end
  end

  generate
    if (GAP > 0) begin : g_gap
      localparam int unsigned GapW = $clog2(GAP + 1);
      logic [GapW-1:0] gap_q;
      always_ff @(posedge i_clk) begin
        if (i_rst)               gap_q <= '0;
        else if (|grant)         gap_q <= GapW'(GAP);
        else if (gap_q != '0)    gap_q <= gap_q - 1'b1;
      end
      assign gap_ok = (gap_q == '0);
    end else begin : g_no_gap
      assign gap_ok = 1'b1;
    end

    if (OREG != 0) begin : g_oreg
      logic [CHANNELS-1:0] pulse_q;
      always_ff @(posedge i_clk) begin
        if (i_rst) pulse_q <= '0;
        else       pulse_q <= grant;
      end
      assign o_pulse = pulse_q;
    end else begin : g_comb_out
      assign o_pulse = grant;
    end
  endgenerate

  assign o_any      = |o_pulse;
  assign o_pending  = eligible;
  assign o_overflow = ovf_q;

endmodule

// File: doc/libhdl_pulse_queue.md
# libhdl_pulse_queue

Single-clock, multi-channel pulse queue and merger. Each of CHANNELS input lines carries single-cycle event pulses. The block counts pending events per channel in a saturating counter and replays them as single-cycle output pulses. Output pulses are issued one at a time, with round-robin fairness and a programmable minimum gap. It sits downstream of pulse synchronisers, where several event sources must be serialised into a rate-limited consumer without losing bursts.

## Interface
- CHANNELS, 4: number of input/output channels, >= 1.
- CNT_W, 4: pending-counter width per channel; capacity 2^CNT_W-1 events.
- GAP, 0: minimum idle cycles between any two output pulses, >= 0.
- OREG, 1: 1 = register o_pulse/o_any (one extra cycle latency); 0 = combinational from state registers.

- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_pulse  in  CHANNELS  event pulses; bit k high for one cycle = one event on channel k; any bits may be high simultaneously.
- i_clrOvf  in  CHANNELS  clear sticky overflow bit k.
- o_pulse  out  CHANNELS  replayed events; at most one bit high per cycle.
- o_any  out  1  OR of o_pulse.
- o_pending  out  CHANNELS  bit k = channel k counter nonzero.
- o_full  out  CHANNELS  bit k = channel k counter at 2^CNT_W-1.
- o_overflow  out  CHANNELS  sticky: an event on channel k was dropped.

## Operation
- Per channel k, cnt[k] (CNT_W bits) is updated each cycle from inc = i_pulse[k] and dec = grant[k]:
  - inc only: cnt+1. If cnt is already at max: unchanged, and overflow[k] sets.
  - dec only: cnt-1.
  - inc and dec: unchanged, no overflow, even at max.
  - neither: unchanged.
- Eligible set: channels with cnt != 0. A grant is allowed only when gapCnt == 0.
- Arbiter: round-robin. ptr holds the highest-priority channel. The search runs ptr, ptr+1, … wrapping modulo CHANNELS. The first eligible channel wins. After a grant to channel j, ptr becomes (j+1) mod CHANNELS. ptr is unchanged when there is no grant.
- Gap counter: on a grant, gapCnt is loaded with GAP. Otherwise it decrements while nonzero. When GAP = 0 the counter is absent and a grant is possible every cycle.
- grant is a one-hot vector. With OREG = 0, o_pulse = grant. With OREG = 1, o_pulse is grant registered once.
- Overflow: set on a dropped event, cleared by i_clrOvf[k]. If set and clear occur in the same cycle, set wins.
- o_pending and o_full derive combinationally from cnt. They reflect the counter after the most recent edge.
- Reset (i_rst high at an edge): all cnt = 0, ptr = 0, gapCnt = 0, overflow = 0, output register = 0.
  - As a result, o_pulse, o_any, o_pending, o_full and o_overflow are all 0 in the cycle after reset.
  - Reset mid-operation discards all pending events with no output pulse.
  - i_pulse is ignored while i_rst is high.

## Timing
- Input pulse sampled at edge t. cnt becomes 1 after edge t.
- Earliest grant is in the cycle following edge t. o_pulse appears then (OREG = 0) or one cycle later (OREG = 1). Minimum latency is therefore 1 or 2 cycles.
- Throughput: one output pulse per GAP+1 cycles aggregate, across all channels.
- With N channels continuously eligible and GAP = 0, each channel is granted exactly once every N cycles.
- A channel's count at the output equals its input count, as long as no overflow occurs.
- Simultaneous pulses on all channels in one cycle: each cnt increments independently. No event is lost unless that channel is full.

## Test plan
- Reset/idle (CHANNELS=4, CNT_W=4, GAP=0, OREG=1): hold i_rst 3 cycles, then release. Required: all outputs 0; o_pulse stays 0 for 20 idle cycles.
- Single event: i_pulse = 4'b0100 for 1 cycle at edge t. Required: o_pulse = 4'b0100 in cycle t+2 only, and o_pending[2] clears after the grant edge.
  - Repeat with OREG=0: o_pulse appears at t+1.
- Burst and fairness: i_pulse = 4'b1111 for 3 cycles. Required: 12 output pulses in order ch0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles; then all o_pending = 0.
- Gap (GAP=3): 5 pulses on ch1. Required: o_pulse[1] high exactly 5 times, with consecutive assertions 4 cycles apart.
- Saturation (CNT_W=2, GAP=7): 5 pulses on ch0 in consecutive cycles with no grants taken during the burst. Required: o_full[0] = 1, o_overflow[0] = 1, exactly 3 output pulses.
  - Then pulse i_clrOvf[0] together with a new dropped event: o_overflow[0] stays 1.
  - A later i_clrOvf[0] alone: o_overflow[0] returns to 0.
- Reset mid-burst: queue 6 events on ch3, assert i_rst after 2 output pulses. Required: no further o_pulse, o_pending = 0. The next event after reset is granted with ptr = 0 priority.
